apple2_line_doubler_ctrl: RTL and testbench

Controller that sequences a two-bank scanline buffer so that each 912-clock Apple ][ video line is emitted as two 456-clock VGA lines.
- Write side: packs serial VIDEO samples into 2-bit words and writes one bank.
- Read side: reads the other bank, holding the previous line, twice, and generates VGA_HS, VGA_VS and VGA_DE aligned to the RAM read data.
- Placement: between the Apple video generator and the colour/monochrome pixel mapper; the buffer RAM is external (1-cycle read latency).

---
 rtl/apple2_line_doubler_ctrl.sv | 170 +++++++++++++++++
 tb/tb_apple2_line_doubler_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple2_line_doubler_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apple2_line_doubler_ctrl
// Description : Two-bank scanline buffer sequencer. Each 912-clock Apple ][
//               line is written into one bank while the other bank is read
//               twice, giving two 456-clock VGA lines with HS/VS/DE timing.
// Revision    : 1.0 - initial release
// ============================================================================
module apple2_line_doubler_ctrl #(
  parameter int ACTIVE_WORDS = 280,
  parameter int HALF_LINE    = 456,
  parameter int RD_START     = 40,
  parameter int HS_START     = 360,
  parameter int HS_LEN       = 68,
  parameter int VBL_TO_VSYNC = 16,
  parameter int VS_LINES     = 2
) (
  input  logic       CLK_14M,
  input  logic       RESET_N,
  input  logic       VIDEO,
  input  logic       HBL,
  input  logic       VBL,
  output logic       WR_EN,
  output logic       WR_BANK,
  output logic [8:0] WR_ADDR,
  output logic [1:0] WR_DATA,
  output logic       RD_EN,
  output logic       RD_BANK,
  output logic [8:0] RD_ADDR,
  output logic       VGA_DE,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_VBL
);

  localparam logic [9:0] c_HCOUNT_MAX  = 10'h3FF;
  localparam logic [9:0] c_LAST_SAMPLE = 10'(2 * ACTIVE_WORDS - 1);
  localparam logic [9:0] c_HALF_LINE   = 10'(HALF_LINE);
  localparam logic [9:0] c_PASS0_LAST  = 10'(HALF_LINE - 1);
  localparam logic [9:0] c_PASS1_LAST  = 10'(2 * HALF_LINE - 1);
  localparam logic [9:0] c_RD_START    = 10'(RD_START);
  localparam logic [9:0] c_RD_END      = 10'(RD_START + ACTIVE_WORDS);
  localparam logic [9:0] c_HS_START    = 10'(HS_START);
  localparam logic [9:0] c_HS_END      = 10'(HS_START + HS_LEN);
  localparam logic [5:0] c_VS_START    = 6'(VBL_TO_VSYNC);
  localparam logic [5:0] c_VS_END      = 6'(VBL_TO_VSYNC + VS_LINES);
  localparam logic [5:0] c_VCOUNT_MAX  = 6'h3F;

  localparam logic [1:0] c_ST_PASS0 = 2'd0;
  localparam logic [1:0] c_ST_PASS1 = 2'd1;
  localparam logic [1:0] c_ST_OVER  = 2'd2;

  logic [9:0] r_hcount;
  logic [5:0] r_vcount;
  logic       r_last_hbl;
  logic       r_bank;
  logic       r_line_valid;
  logic       r_video_prev;
  logic       r_hs_d;
  logic [1:0] r_state;
  logic [1:0] w_state_next;

  logic       w_line_start;
  logic       w_pass_act;
  logic [9:0] w_pos;
  logic       w_wr;
  logic       w_rd;
  logic       w_hs;
  logic       w_vs;

  assign w_line_start = r_last_hbl & ~HBL;

  // Line timing: hcount, bank swap, per-line VBL bookkeeping
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_last_hbl   <= 1'b0;
      r_bank       <= 1'b0;
      r_line_valid <= 1'b0;
      r_video_prev <= 1'b0;
      VGA_VBL      <= 1'b0;
    end else begin
      r_last_hbl   <= HBL;
      r_video_prev <= VIDEO;
      if (w_line_start) begin
        r_hcount     <= '0;
        r_bank       <= ~r_bank;
        VGA_VBL      <= VBL;
        r_line_valid <= ~VBL;
        if (VBL) begin
          if (r_vcount != c_VCOUNT_MAX) r_vcount <= r_vcount + 6'd1;
        end else begin
          r_vcount <= '0;
        end
      end else if (r_hcount != c_HCOUNT_MAX) begin
        r_hcount <= r_hcount + 10'd1;
      end
    end
  end

  // Read-pass state tracks which half of the Apple line hcount sits in
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) r_state <= c_ST_PASS0;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_line_start) begin
      w_state_next = c_ST_PASS0;
    end else begin
      case (r_state)
        c_ST_PASS0: if (r_hcount == c_PASS0_LAST) w_state_next = c_ST_PASS1;
        c_ST_PASS1: if (r_hcount == c_PASS1_LAST) w_state_next = c_ST_OVER;
        default:    w_state_next = c_ST_OVER;
      endcase
    end
  end

  always_comb begin
    w_pass_act = 1'b0;
    w_pos      = r_hcount;
    case (r_state)
      c_ST_PASS0: w_pass_act = 1'b1;
      c_ST_PASS1: begin
        w_pass_act = 1'b1;
        w_pos      = r_hcount - c_HALF_LINE;
      end
      default: w_pass_act = 1'b0;
    endcase
  end

  assign w_wr = ~VBL & r_hcount[0] & (r_hcount <= c_LAST_SAMPLE);
  assign w_rd = w_pass_act & r_line_valid & (w_pos >= c_RD_START) & (w_pos < c_RD_END);
  assign w_hs = w_pass_act & (w_pos >= c_HS_START) & (w_pos < c_HS_END);
  assign w_vs = (r_vcount >= c_VS_START) & (r_vcount < c_VS_END);

  // Bank is registered alongside the strobes so a write issued on the
  // line-start cycle still lands in the bank that line was filling.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      WR_EN   <= 1'b0;
      WR_BANK <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      RD_EN   <= 1'b0;
      RD_ADDR <= '0;
      VGA_DE  <= 1'b0;
      r_hs_d  <= 1'b0;
      VGA_HS  <= 1'b0;
      VGA_VS  <= 1'b0;
    end else begin
      WR_EN   <= w_wr;
      WR_BANK <= r_bank;
      WR_ADDR <= w_wr ? r_hcount[9:1] : 9'd0;
      WR_DATA <= w_wr ? {VIDEO, r_video_prev} : 2'd0;
      RD_EN   <= w_rd;
      RD_ADDR <= w_rd ? 9'(w_pos - c_RD_START) : 9'd0;
      VGA_DE  <= RD_EN;
      r_hs_d  <= w_hs;
      VGA_HS  <= r_hs_d;
      VGA_VS  <= w_vs;
    end
  end

  assign RD_BANK = ~WR_BANK;

endmodule
`default_nettype wire

// File: tb/tb_apple2_line_doubler_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apple2_line_doubler_ctrl
// Description : Scoreboard bench for the Apple ][ scanline doubler controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apple2_line_doubler_ctrl;

  logic       CLK_14M = 1'b0;
  logic       RESET_N = 1'b0;
  logic       VIDEO = 1'b0;
  logic       HBL = 1'b0;
  logic       VBL = 1'b0;
  logic       WR_EN, WR_BANK, RD_EN, RD_BANK, VGA_DE, VGA_HS, VGA_VS, VGA_VBL;
  logic [8:0] WR_ADDR, RD_ADDR;
  logic [1:0] WR_DATA;

  apple2_line_doubler_ctrl dut (
    .CLK_14M(CLK_14M), .RESET_N(RESET_N), .VIDEO(VIDEO), .HBL(HBL), .VBL(VBL),
    .WR_EN(WR_EN), .WR_BANK(WR_BANK), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_BANK(RD_BANK), .RD_ADDR(RD_ADDR),
    .VGA_DE(VGA_DE), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_VBL(VGA_VBL)
  );

  always #5 CLK_14M = ~CLK_14M;

  typedef struct { int due; logic bank; logic [8:0] addr; logic [1:0] data; } wr_t;
  typedef struct { int due; logic bank; logic [8:0] addr; } rd_t;
  typedef struct { int due; logic de; logic hs; logic vs; logic vbl; } cy_t;

  wr_t wq[$];
  rd_t rq[$];
  cy_t cq[$];

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int wr_cnt, rd_cnt, hs_cnt, vs_cnt, vbl_cnt, rdb1_cnt;
  logic [8:0] wr_last;
  logic [1:0] wr_and, wr_or;

  int   m_h, m_vcount;
  logic m_bank, m_valid, m_last_hbl, m_prev_vid, m_vbl_out, m_prev_rd, m_prev_hs;

  always @(posedge CLK_14M) edge_n <= edge_n + 1;

  // Scoreboard pops and per-cycle VGA timing compares
  always @(negedge CLK_14M) begin
    wr_t w;
    rd_t r;
    cy_t c;
    if (RESET_N === 1'b1) begin
      if (WR_EN === 1'b1) begin
        wr_cnt++; wr_last = WR_ADDR; wr_and &= WR_DATA; wr_or |= WR_DATA;
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_spurious: got write addr=%0d at edge %0d, required no write", WR_ADDR, edge_n);
        end else begin
          w = wq.pop_front();
          if (w.due !== edge_n || {WR_BANK, WR_ADDR, WR_DATA} !== {w.bank, w.addr, w.data}) begin
            errors++;
            $display("FAIL wr_item: got edge=%0d bank=%0d addr=%0d data=%b, required edge=%0d bank=%0d addr=%0d data=%b",
                     edge_n, WR_BANK, WR_ADDR, WR_DATA, w.due, w.bank, w.addr, w.data);
          end
        end
      end else if (wq.size() != 0 && wq[0].due <= edge_n) begin
        checks++; errors++;
        $display("FAIL wr_missing: got no write at edge %0d, required addr=%0d", edge_n, wq[0].addr);
        void'(wq.pop_front());
      end

      if (RD_EN === 1'b1) begin
        rd_cnt++;
        if (RD_BANK === 1'b1) rdb1_cnt++;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rd_spurious: got read addr=%0d at edge %0d, required no read", RD_ADDR, edge_n);
        end else begin
          r = rq.pop_front();
          if (r.due !== edge_n || {RD_BANK, RD_ADDR} !== {r.bank, r.addr}) begin
            errors++;
            $display("FAIL rd_item: got edge=%0d bank=%0d addr=%0d, required edge=%0d bank=%0d addr=%0d",
                     edge_n, RD_BANK, RD_ADDR, r.due, r.bank, r.addr);
          end
        end
      end else if (rq.size() != 0 && rq[0].due <= edge_n) begin
        checks++; errors++;
        $display("FAIL rd_missing: got no read at edge %0d, required addr=%0d", edge_n, rq[0].addr);
        void'(rq.pop_front());
      end

      if (VGA_HS === 1'b1) hs_cnt++;
      if (VGA_VS === 1'b1) vs_cnt++;
      if (VGA_VBL === 1'b1) vbl_cnt++;
      if (cq.size() != 0 && cq[0].due <= edge_n) begin
        c = cq.pop_front();
        checks++;
        if (c.due !== edge_n || {VGA_DE, VGA_HS, VGA_VS, VGA_VBL} !== {c.de, c.hs, c.vs, c.vbl}) begin
          errors++;
          $display("FAIL vga_timing: edge %0d got de/hs/vs/vbl=%b%b%b%b, required %b%b%b%b (due %0d)",
                   edge_n, VGA_DE, VGA_HS, VGA_VS, VGA_VBL, c.de, c.hs, c.vs, c.vbl, c.due);
        end
      end
    end
  end

  task automatic clr_cnt();
    wr_cnt = 0; rd_cnt = 0; hs_cnt = 0; vs_cnt = 0; vbl_cnt = 0; rdb1_cnt = 0;
    wr_last = '0; wr_and = 2'b11; wr_or = 2'b00;
  endtask

  function automatic logic vid_of(input int mode, input int j);
    if (mode == 1) return logic'(j % 2 == 0);
    if (mode == 2) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus; expectations derived from the line-timing rules
  task automatic cyc(input logic hbl, input logic vbl, input logic vid);
    logic start, act, rd, hs;
    int   r;
    HBL = hbl; VBL = vbl; VIDEO = vid;
    start = m_last_hbl && !hbl;
    if (!vbl && (m_h % 2 == 1) && m_h <= 559)
      wq.push_back('{edge_n + 1, m_bank, 9'(m_h / 2), {vid, m_prev_vid}});
    act = (m_h < 912);
    r   = (m_h >= 456) ? m_h - 456 : m_h;
    rd  = act && m_valid && r >= 40 && r < 320;
    hs  = act && r >= 360 && r < 428;
    if (rd) rq.push_back('{edge_n + 1, !m_bank, 9'(r - 40)});
    cq.push_back('{edge_n + 1, m_prev_rd, m_prev_hs,
                   logic'(m_vcount >= 16 && m_vcount < 18), start ? vbl : m_vbl_out});
    m_prev_rd = rd; m_prev_hs = hs;
    if (start) begin
      m_h = 0; m_bank = !m_bank; m_vbl_out = vbl; m_valid = !vbl;
      m_vcount = vbl ? ((m_vcount < 63) ? m_vcount + 1 : 63) : 0;
    end else if (m_h < 1023) begin
      m_h++;
    end
    m_last_hbl = hbl; m_prev_vid = vid;
    @(posedge CLK_14M); #1;
  endtask

  // Apple line of L clocks: HBL pulses so line start lands on the last clock
  task automatic line(input int L, input logic vbl, input int mode);
    for (int j = 0; j < L; j++) cyc(logic'(j == L - 2), vbl, vid_of(mode, j));
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; HBL = 1'b0; VBL = 1'b0; VIDEO = 1'b0;
    wq.delete(); rq.delete(); cq.delete();
    m_h = 0; m_vcount = 0; m_bank = 0; m_valid = 0; m_last_hbl = 0;
    m_prev_vid = 0; m_vbl_out = 0; m_prev_rd = 0; m_prev_hs = 0;
    #1;
    checks++;
    if ({WR_EN, WR_BANK, WR_ADDR, WR_DATA, RD_EN, RD_ADDR, VGA_DE, VGA_HS, VGA_VS, VGA_VBL} !== 27'd0
        || RD_BANK !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b bank=%b waddr=%0d wdata=%b rd=%b rbank=%b raddr=%0d de/hs/vs/vbl=%b%b%b%b, required all 0 with RD_BANK=1",
               WR_EN, WR_BANK, WR_ADDR, WR_DATA, RD_EN, RD_BANK, RD_ADDR, VGA_DE, VGA_HS, VGA_VS, VGA_VBL);
    end
    repeat (3) @(posedge CLK_14M);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_first_lines();
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (wr_cnt !== 280) begin errors++; $display("FAIL first_wr_count: got %0d, required 280", wr_cnt); end
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL first_rd_count: got %0d, required 0", rd_cnt); end
    checks++; if (hs_cnt !== 136) begin errors++; $display("FAIL first_hs_clocks: got %0d, required 136", hs_cnt); end
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (rd_cnt !== 560) begin errors++; $display("FAIL second_rd_count: got %0d, required 560", rd_cnt); end
    checks++; if (rdb1_cnt !== 0) begin errors++; $display("FAIL second_rd_bank: got %0d reads from bank 1, required 0", rdb1_cnt); end
  endtask

  task automatic test_video_patterns();
    clr_cnt();
    line(912, 1'b0, 1);
    checks++;
    if (wr_and !== 2'b01 || wr_or !== 2'b01) begin
      errors++; $display("FAIL alt_wr_data: got and=%b or=%b, required all 01", wr_and, wr_or);
    end
    clr_cnt();
    line(912, 1'b0, 2);
    checks++;
    if (wr_and !== 2'b11 || wr_or !== 2'b11) begin
      errors++; $display("FAIL ones_wr_data: got and=%b or=%b, required all 11", wr_and, wr_or);
    end
  endtask

  task automatic test_short_line();
    clr_cnt();
    line(600, 1'b0, 0);
    checks++; if (wr_cnt !== 280) begin errors++; $display("FAIL short_wr_count: got %0d, required 280", wr_cnt); end
    checks++; if (wr_last !== 9'd279) begin errors++; $display("FAIL short_last_addr: got %0d, required 279", wr_last); end
    line(560, 1'b0, 0);
    line(912, 1'b0, 0);
    checks++; if (wr_cnt !== 840) begin errors++; $display("FAIL short_wr_total: got %0d, required 840", wr_cnt); end
    checks++; if (rd_cnt !== 1288) begin errors++; $display("FAIL short_rd_total: got %0d, required 1288", rd_cnt); end
  endtask

  task automatic test_long_line();
    clr_cnt();
    line(1100, 1'b0, 0);
    checks++; if (rd_cnt !== 560) begin errors++; $display("FAIL long_rd_count: got %0d, required 560", rd_cnt); end
    checks++; if (hs_cnt !== 136) begin errors++; $display("FAIL long_hs_clocks: got %0d, required 136", hs_cnt); end
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (rd_cnt !== 560) begin errors++; $display("FAIL after_long_rd: got %0d, required 560", rd_cnt); end
  endtask

  task automatic test_vbl();
    line(912, 1'b0, 0);
    clr_cnt();
    for (int n = 0; n < 20; n++) line(912, 1'b1, 0);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL vbl_wr_count: got %0d, required 0", wr_cnt); end
    checks++; if (rd_cnt !== 560) begin errors++; $display("FAIL vbl_rd_count: got %0d, required 560", rd_cnt); end
    checks++; if (vs_cnt !== 1824) begin errors++; $display("FAIL vsync_clocks: got %0d, required 1824", vs_cnt); end
    checks++; if (vbl_cnt !== 19 * 912) begin errors++; $display("FAIL vga_vbl_clocks: got %0d, required %0d", vbl_cnt, 19 * 912); end
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL post_vbl_rd: got %0d, required 0", rd_cnt); end
    checks++; if (wr_cnt !== 280) begin errors++; $display("FAIL post_vbl_wr: got %0d, required 280", wr_cnt); end
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (rd_cnt !== 560) begin errors++; $display("FAIL post_vbl_rd2: got %0d, required 560", rd_cnt); end
  endtask

  task automatic test_reset_midline();
    for (int j = 0; j <= 300; j++) cyc(1'b0, 1'b0, vid_of(0, j));
    do_reset();
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (wr_cnt !== 280) begin errors++; $display("FAIL rst_line_wr: got %0d, required 280", wr_cnt); end
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL rst_line_rd: got %0d, required 0", rd_cnt); end
    clr_cnt();
    line(912, 1'b0, 0);
    checks++; if (rd_cnt !== 560) begin errors++; $display("FAIL rst_next_rd: got %0d, required 560", rd_cnt); end
  endtask

  task automatic test_drain();
    @(negedge CLK_14M); #1;
    checks++;
    if (wq.size() != 0 || rq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending wr=%0d rd=%0d cyc=%0d, required 0/0/0", wq.size(), rq.size(), cq.size());
    end
  endtask

  initial begin
    clr_cnt();
    test_reset();
    test_first_lines();
    test_video_patterns();
    test_short_line();
    test_long_line();
    test_vbl();
    test_reset_midline();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
